// File: rtl/stream_frame_sequencer_pkg.sv
// Shared constants, FSM encoding and debug struct for the stream frame sequencer.
// Contents:
//   DEF_* constants : global pixel width, frame geometry and pad pixel
//   state_t         : sequencer FSM states
//   dbg_t           : debug view of FSM state and input raster position
//   out_span()      : output active cycles per frame (H*W plus H-1 line gaps)
package stream_frame_sequencer_pkg;

  localparam int PIXEL_SIZE       = 24;
  localparam int COORD_W          = 16;
  localparam int DEF_FRAME_WIDTH  = 640;
  localparam int DEF_FRAME_HEIGHT = 480;
  localparam logic [PIXEL_SIZE-1:0] DEF_PAD_PIXEL = '0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_HSYNC  = 3'd3,
    ST_FLUSH  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  typedef struct packed {
    state_t               state;
    logic [COORD_W-1:0]   in_x;
    logic [COORD_W-1:0]   in_y;
  } dbg_t;

  function automatic int out_span(input int w, input int h);
    return w * h + h - 1;
  endfunction

endpackage

// File: rtl/stream_frame_sequencer_line_timer.sv
// Raster counter: W active positions per line, a 1-cycle gap between lines,
// H lines, no gap after the last line (wraps straight back to 0,0).
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   clear_i        : return to (0,0) active; has priority over step_i
//   step_i         : advance one raster position
//   x_o, y_o       : current position
//   gap_o          : current cycle is the inter-line gap
//   last_o         : current cycle is the last active position of the frame
module stream_frame_sequencer_line_timer
  import stream_frame_sequencer_pkg::*;
#(
  parameter int W = DEF_FRAME_WIDTH,
  parameter int H = DEF_FRAME_HEIGHT
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               step_i,
  output logic [COORD_W-1:0] x_o,
  output logic [COORD_W-1:0] y_o,
  output logic               gap_o,
  output logic               last_o
);

  localparam logic [COORD_W-1:0] XMAX = COORD_W'(W - 1);
  localparam logic [COORD_W-1:0] YMAX = COORD_W'(H - 1);

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               gap_q, gap_d;

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    gap_d = gap_q;
    if (clear_i) begin
      x_d   = '0;
      y_d   = '0;
      gap_d = 1'b0;
    end else if (step_i) begin
      if (gap_q) begin
        gap_d = 1'b0;
        x_d   = '0;
        y_d   = y_q + 1'b1;
      end else if (x_q == XMAX) begin
        if (y_q == YMAX) begin
          x_d = '0;
          y_d = '0;
        end else begin
          gap_d = 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      x_q   <= '0;
      y_q   <= '0;
      gap_q <= 1'b0;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      gap_q <= gap_d;
    end
  end

  assign x_o    = x_q;
  assign y_o    = y_q;
  assign gap_o  = gap_q;
  assign last_o = !gap_q && (x_q == XMAX) && (y_q == YMAX);

endmodule

// File: rtl/stream_frame_sequencer.sv
// Feeds one frame at a time into a free-running pixel pipeline and tags its output.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   start, cont           : begin a frame (IDLE only); auto-restart after DONE
//   s_valid/s_data/s_ready: source pixel stream
//   p_en/p_hsync/p_vsync/p_data : pipeline drive; p_out : pipeline result
//   m_valid/m_data/m_x/m_y: tagged, registered pipeline output
//   busy, frame_done, frame_count, underrun_cnt : status
//   dbg_o                 : FSM state and input raster position
// Source handshake: a pixel transfers in every cycle where s_ready is high;
// s_valid low in such a cycle is an underrun (pad pixel sent, slot lost) --
// the pipeline never stalls, so s_ready does not wait on s_valid.
module stream_frame_sequencer
  import stream_frame_sequencer_pkg::*;
#(
  parameter int                      FRAME_WIDTH  = DEF_FRAME_WIDTH,
  parameter int                      FRAME_HEIGHT = DEF_FRAME_HEIGHT,
  parameter int                      PIPE_LATENCY = 1283,
  parameter logic [PIXEL_SIZE-1:0]   PAD_PIXEL    = DEF_PAD_PIXEL
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  cont,
  input  logic                  s_valid,
  input  logic [PIXEL_SIZE-1:0] s_data,
  output logic                  s_ready,
  output logic                  p_en,
  output logic                  p_hsync,
  output logic                  p_vsync,
  output logic [PIXEL_SIZE-1:0] p_data,
  input  logic [PIXEL_SIZE-1:0] p_out,
  output logic                  m_valid,
  output logic [PIXEL_SIZE-1:0] m_data,
  output logic [COORD_W-1:0]    m_x,
  output logic [COORD_W-1:0]    m_y,
  output logic                  busy,
  output logic                  frame_done,
  output logic [15:0]           frame_count,
  output logic [15:0]           underrun_cnt,
  output dbg_t                  dbg_o
);

  localparam int OUT_SPAN = out_span(FRAME_WIDTH, FRAME_HEIGHT);
  localparam int CNT_W    = $clog2(PIPE_LATENCY + OUT_SPAN + 2);
  localparam logic [CNT_W-1:0]   LAT_C = CNT_W'(PIPE_LATENCY);
  localparam logic [CNT_W-1:0]   END_C = CNT_W'(PIPE_LATENCY + OUT_SPAN);
  localparam logic [COORD_W-1:0] XMAX  = COORD_W'(FRAME_WIDTH - 1);

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [15:0]             frame_count_q, frame_count_d;
  logic [15:0]             underrun_q, underrun_d;
  logic                    m_valid_q, m_valid_d;
  logic [PIXEL_SIZE-1:0]   m_data_q, m_data_d;
  logic [COORD_W-1:0]      m_x_q, m_x_d, m_y_q, m_y_d;
  logic                    last_tag_q, last_tag_d;

  logic                    running, out_run, timer_clear;
  logic [COORD_W-1:0]      in_x, in_y, out_x, out_y;
  logic                    in_gap, in_last, out_gap, out_last;

  assign running     = (state_q == ST_ACTIVE) || (state_q == ST_HSYNC) || (state_q == ST_FLUSH);
  assign timer_clear = (state_q == ST_VSYNC);
  // cnt_q counts cycles since the first ACTIVE cycle; the output raster runs
  // for OUT_SPAN cycles starting PIPE_LATENCY cycles later.
  assign out_run     = running && (cnt_q >= LAT_C) && (cnt_q < END_C);

  stream_frame_sequencer_line_timer #(.W(FRAME_WIDTH), .H(FRAME_HEIGHT)) u_in_timer (
    .clk_i(clk), .reset_i(reset), .clear_i(timer_clear), .step_i(running),
    .x_o(in_x), .y_o(in_y), .gap_o(in_gap), .last_o(in_last)
  );

  stream_frame_sequencer_line_timer #(.W(FRAME_WIDTH), .H(FRAME_HEIGHT)) u_out_timer (
    .clk_i(clk), .reset_i(reset), .clear_i(timer_clear), .step_i(out_run),
    .x_o(out_x), .y_o(out_y), .gap_o(out_gap), .last_o(out_last)
  );

  // FSM next state and pipeline drive
  always_comb begin
    state_d    = state_q;
    s_ready    = 1'b0;
    p_hsync    = 1'b0;
    p_vsync    = 1'b0;
    frame_done = 1'b0;
    p_data     = PAD_PIXEL;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_VSYNC;
      ST_VSYNC: begin
        p_vsync = 1'b1;
        state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        s_ready = 1'b1;
        if (s_valid) p_data = s_data;
        if (in_last)           state_d = ST_FLUSH;
        else if (in_x == XMAX) state_d = ST_HSYNC;
      end
      ST_HSYNC: begin
        p_hsync = 1'b1;
        state_d = ST_ACTIVE;
      end
      ST_FLUSH: begin
        // the input raster keeps running so hsync keeps its line cadence
        p_hsync = in_gap;
        if (last_tag_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        frame_done = 1'b1;
        state_d    = cont ? ST_VSYNC : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // counters and output tagging
  always_comb begin
    cnt_d         = cnt_q;
    underrun_d    = underrun_q;
    frame_count_d = frame_count_q;
    if (state_q == ST_VSYNC) begin
      cnt_d      = '0;
      underrun_d = '0;
    end else if (running) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (state_q == ST_ACTIVE && !s_valid && underrun_q != 16'hFFFF)
      underrun_d = underrun_q + 16'd1;
    if (state_q == ST_DONE)
      frame_count_d = frame_count_q + 16'd1;
    m_valid_d  = out_run && !out_gap;
    m_data_d   = p_out;
    m_x_d      = out_x;
    m_y_d      = out_y;
    // goes high in the same cycle the last m_valid is presented
    last_tag_d = out_run && out_last;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      underrun_q    <= '0;
      frame_count_q <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      m_x_q         <= '0;
      m_y_q         <= '0;
      last_tag_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      underrun_q    <= underrun_d;
      frame_count_q <= frame_count_d;
      m_valid_q     <= m_valid_d;
      m_data_q      <= m_data_d;
      m_x_q         <= m_x_d;
      m_y_q         <= m_y_d;
      last_tag_q    <= last_tag_d;
    end
  end

  assign p_en         = (state_q != ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;
  assign m_x          = m_x_q;
  assign m_y          = m_y_q;
  assign frame_count  = frame_count_q;
  assign underrun_cnt = underrun_q;
  assign dbg_o        = '{state: state_q, in_x: in_x, in_y: in_y};

endmodule

// File: tb/tb_stream_frame_sequencer.sv
// Bench for stream_frame_sequencer: two instances (latency 19 and 1) share one
// stimulus stream; each is fronted by a pure delay line standing in for the pipeline.
module tb_stream_frame_sequencer;
  import stream_frame_sequencer_pkg::*;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int OS   = W * H + H - 1;
  localparam int LAT0 = 19;
  localparam int LAT1 = 1;
  localparam logic [23:0] PAD = 24'h5A5A5A;

  // clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, cont, s_valid;
  logic [23:0] s_data;

  logic        s_ready_w [2];
  logic        p_en_w [2];
  logic        p_hsync_w [2];
  logic        p_vsync_w [2];
  logic [23:0] p_data_w [2];
  logic [23:0] p_out_w [2];
  logic        m_valid_w [2];
  logic [23:0] m_data_w [2];
  logic [15:0] m_x_w [2];
  logic [15:0] m_y_w [2];
  logic        busy_w [2];
  logic        frame_done_w [2];
  logic [15:0] fc_w [2];
  logic [15:0] ur_w [2];
  dbg_t        dbg_w [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    localparam int LAT = (gi == 0) ? LAT0 : LAT1;
    logic [23:0] dl [LAT];
    always @(posedge clk) begin
      dl[0] <= p_data_w[gi];
      for (int j = 1; j < LAT; j++) dl[j] <= dl[j-1];
    end
    assign p_out_w[gi] = dl[LAT-1];

    stream_frame_sequencer #(
      .FRAME_WIDTH(W), .FRAME_HEIGHT(H), .PIPE_LATENCY(LAT), .PAD_PIXEL(PAD)
    ) u_dut (
      .clk(clk), .reset(reset), .start(start), .cont(cont),
      .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready_w[gi]),
      .p_en(p_en_w[gi]), .p_hsync(p_hsync_w[gi]), .p_vsync(p_vsync_w[gi]),
      .p_data(p_data_w[gi]), .p_out(p_out_w[gi]),
      .m_valid(m_valid_w[gi]), .m_data(m_data_w[gi]), .m_x(m_x_w[gi]), .m_y(m_y_w[gi]),
      .busy(busy_w[gi]), .frame_done(frame_done_w[gi]),
      .frame_count(fc_w[gi]), .underrun_cnt(ur_w[gi]), .dbg_o(dbg_w[gi])
    );
  end

  // scoreboard state
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // behavioural model: per instance, frame start time and counters
  bit          mb [2];
  int          mt0 [2];
  int          mfc [2];
  int          mur [2];
  logic [23:0] pix [2][OS];

  // observations for literal timing checks
  int          vs_c [2];
  int          first_mv [2];
  int          last_mv [2];
  int          done_c [2];
  int          done_n [2];
  logic [15:0] lx [2];
  logic [15:0] ly [2];
  logic [23:0] hole_md [2];

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, i, cyc, act, exp);
    end
  endtask

  task automatic check_cycle();
    for (int i = 0; i < 2; i++) begin
      int lat, n, k;
      logic e_rdy, e_hs, e_vs, e_done, e_mv;
      logic [23:0] e_pd, e_md;
      int e_mx, e_my;
      lat = (i == 0) ? LAT0 : LAT1;
      n = cyc - mt0[i];
      e_rdy = 0; e_hs = 0; e_vs = 0; e_done = 0; e_mv = 0;
      e_pd = PAD; e_md = '0; e_mx = 0; e_my = 0;
      if (mb[i]) begin
        if (n == -1) e_vs = 1;
        else if (n >= 0 && n < OS) begin
          if (n % (W + 1) == W) e_hs = 1;
          else begin
            e_rdy = 1;
            e_pd = s_valid ? s_data : PAD;
          end
        end else if (n >= OS && n <= lat + OS) e_hs = ((n % OS) % (W + 1) == W);
        else if (n == lat + OS + 1) e_done = 1;
        if (n >= lat + 1 && n <= lat + OS) begin
          k = n - lat - 1;
          if (k % (W + 1) < W) begin
            e_mv = 1;
            e_mx = k % (W + 1);
            e_my = k / (W + 1);
            e_md = pix[i][k];
          end
        end
      end
      if (chk_en) begin
        chk("s_ready", i, 32'(s_ready_w[i]), 32'(e_rdy));
        chk("p_en", i, 32'(p_en_w[i]), 32'(mb[i]));
        chk("busy", i, 32'(busy_w[i]), 32'(mb[i]));
        chk("p_hsync", i, 32'(p_hsync_w[i]), 32'(e_hs));
        chk("p_vsync", i, 32'(p_vsync_w[i]), 32'(e_vs));
        chk("p_data", i, 32'(p_data_w[i]), 32'(e_pd));
        chk("frame_done", i, 32'(frame_done_w[i]), 32'(e_done));
        chk("m_valid", i, 32'(m_valid_w[i]), 32'(e_mv));
        chk("frame_count", i, 32'(fc_w[i]), 32'(mfc[i]));
        chk("underrun_cnt", i, 32'(ur_w[i]), 32'(mur[i]));
        if (e_mv) begin
          chk("m_data", i, 32'(m_data_w[i]), 32'(e_md));
          chk("m_x", i, 32'(m_x_w[i]), e_mx);
          chk("m_y", i, 32'(m_y_w[i]), e_my);
        end
      end
      // observations
      if (p_vsync_w[i]) begin vs_c[i] = cyc; first_mv[i] = -1; end
      if (m_valid_w[i]) begin
        if (first_mv[i] == -1) first_mv[i] = cyc;
        last_mv[i] = cyc; lx[i] = m_x_w[i]; ly[i] = m_y_w[i];
        if (m_x_w[i] == 16'd3 && m_y_w[i] == 16'd1) hole_md[i] = m_data_w[i];
      end
      if (frame_done_w[i]) begin done_c[i] = cyc; done_n[i]++; end
      // model transition on the inputs sampled at the coming edge
      if (reset) begin
        mb[i] = 0; mfc[i] = 0; mur[i] = 0;
      end else if (!mb[i]) begin
        if (start) begin mb[i] = 1; mt0[i] = cyc + 2; end
      end else begin
        if (n == -1) mur[i] = 0;
        if (n >= 0 && n < OS && (n % (W + 1) != W)) begin
          pix[i][n] = s_valid ? s_data : PAD;
          if (!s_valid && mur[i] < 65535) mur[i]++;
        end
        if (n == lat + OS + 1) begin
          mfc[i] = (mfc[i] + 1) % 65536;
          if (cont) mt0[i] = cyc + 2;
          else mb[i] = 0;
        end
      end
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
    check_cycle();
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int j = 0; j < n; j++) begin
      s_data = 24'($urandom);
      tick();
    end
  endtask

  initial begin
    int c0, budget;
    int d0 [2];
    for (int i = 0; i < 2; i++) begin
      mb[i] = 0; mt0[i] = 0; mfc[i] = 0; mur[i] = 0;
      vs_c[i] = 0; first_mv[i] = -1; last_mv[i] = 0; done_c[i] = 0; done_n[i] = 0;
      lx[i] = '0; ly[i] = '0; hole_md[i] = '0;
    end
    reset = 1; start = 0; cont = 0; s_valid = 0; s_data = '0;
    tick();
    chk_en = 1'b1;
    ticks(2);
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", i, 32'(busy_w[i]), 32'd0);
      chk("rst_p_data", i, 32'(p_data_w[i]), 32'h5A5A5A);
      chk("rst_state", i, 32'(dbg_w[i].state), 32'(ST_IDLE));
      chk("rst_fc", i, 32'(fc_w[i]), 32'd0);
    end

    // one full frame, all pixels valid, stray start mid-frame
    s_valid = 1; start = 1;
    ticks(1);
    start = 0;
    for (int j = 0; j < 70; j++) begin
      start = (j == 10);
      ticks(1);
    end
    start = 0;
    for (int i = 0; i < 2; i++) begin
      chk("first_mv_lat", i, first_mv[i] - vs_c[i] - 1, (i == 0) ? 20 : 2);
      chk("last_mv_lat", i, last_mv[i] - vs_c[i] - 1, (i == 0) ? 54 : 36);
      chk("last_x", i, 32'(lx[i]), 32'd7);
      chk("last_y", i, 32'(ly[i]), 32'd3);
      chk("done_lat", i, done_c[i] - vs_c[i] - 1, (i == 0) ? 55 : 37);
      chk("fc_after_1", i, 32'(fc_w[i]), 32'd1);
    end

    // underrun at raster (3,1) = t0+12
    c0 = cyc;
    start = 1;
    ticks(1);
    start = 0;
    for (int j = 0; j < 70; j++) begin
      s_valid = (cyc != c0 + 14);
      ticks(1);
    end
    s_valid = 1;
    for (int i = 0; i < 2; i++) begin
      chk("underrun_one", i, 32'(ur_w[i]), 32'd1);
      chk("fc_after_2", i, 32'(fc_w[i]), 32'd2);
      chk("hole_pixel", i, 32'(hole_md[i]), 32'h5A5A5A);
    end

    // reset mid-ACTIVE
    d0[0] = done_n[0]; d0[1] = done_n[1];
    start = 1;
    ticks(1);
    start = 0;
    ticks(12);
    reset = 1;
    ticks(3);
    reset = 0;
    for (int i = 0; i < 2; i++) begin
      chk("midrst_busy", i, 32'(busy_w[i]), 32'd0);
      chk("midrst_p_data", i, 32'(p_data_w[i]), 32'h5A5A5A);
      chk("midrst_m_valid", i, 32'(m_valid_w[i]), 32'd0);
    end
    ticks(5);
    for (int i = 0; i < 2; i++) chk("midrst_no_done", i, done_n[i], d0[i]);

    // continuous mode with random underruns
    cont = 1;
    start = 1;
    for (int j = 0; j < 250; j++) begin
      s_valid = ($urandom_range(0, 7) != 0);
      ticks(1);
      start = 0;
    end
    cont = 0;
    for (int j = 0; j < 100; j++) begin
      s_valid = ($urandom_range(0, 7) != 0);
      ticks(1);
    end

    // fully random control
    for (int j = 0; j < 800; j++) begin
      start   = ($urandom_range(0, 19) == 0);
      cont    = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 299) == 0);
      s_valid = ($urandom_range(0, 5) != 0);
      ticks(1);
    end
    start = 0; cont = 0; reset = 0;

    budget = 300;
    while ((busy_w[0] || busy_w[1]) && budget > 0) begin
      ticks(1);
      budget--;
    end
    chk("drain_idle", 0, 32'(busy_w[0]), 32'd0);
    chk("drain_idle", 1, 32'(busy_w[1]), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
